// File: rtl/mem_dbus_bridge.sv
// Data-side bridge from the MEM stage's single-cycle SRAM-style access to the
// request / address-ack / data-ack external data bus, with pipeline stall and flush draining.
module mem_dbus_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        pipe_stall_i,
  input  logic        flush_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_req_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        latch_req, capture, clear_rdata;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rdata_q;
  logic        sel_ok;
  logic [1:0]  dec_size, dec_off;

  // Byte-enable pattern to bus size and low address bits; other patterns never reach the bus.
  always_comb begin
    sel_ok   = 1'b1;
    dec_size = 2'd0;
    dec_off  = 2'd0;
    case (mem_sel_i)
      4'b0001: begin dec_size = 2'd0; dec_off = 2'd0; end
      4'b0010: begin dec_size = 2'd0; dec_off = 2'd1; end
      4'b0100: begin dec_size = 2'd0; dec_off = 2'd2; end
      4'b1000: begin dec_size = 2'd0; dec_off = 2'd3; end
      4'b0011: begin dec_size = 2'd1; dec_off = 2'd0; end
      4'b1100: begin dec_size = 2'd1; dec_off = 2'd2; end
      4'b0111, 4'b1110, 4'b1111: begin dec_size = 2'd2; dec_off = 2'd0; end
      default: sel_ok = 1'b0;
    endcase
  end

  // pend_q marks a DRAIN whose request has not yet been address-acked.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    latch_req   = 1'b0;
    capture     = 1'b0;
    clear_rdata = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_ce_i && !flush_i) begin
          if (sel_ok) begin
            state_d   = S_REQ;
            latch_req = 1'b1;
          end else begin
            state_d     = S_DONE;
            clear_rdata = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (data_addr_ok_i) begin
          state_d = flush_i ? S_DRAIN : S_WAIT;
          pend_d  = 1'b0;
        end else if (flush_i) begin
          state_d = S_DRAIN;
          pend_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (data_data_ok_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            capture = 1'b1;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
          pend_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (flush_i || !pipe_stall_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (pend_q) begin
          if (data_addr_ok_i) pend_d = 1'b0;
        end else if (data_data_ok_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      req_we    <= 1'b0;
      req_sel   <= 4'd0;
      req_size  <= 2'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (latch_req) begin
        req_we    <= mem_we_i;
        req_sel   <= mem_sel_i;
        req_size  <= dec_size;
        req_addr  <= {mem_addr_i[31:2], dec_off};
        req_wdata <= mem_data_i;
      end
      if (capture) rdata_q <= data_rdata_i;
      else if (clear_rdata) rdata_q <= 32'd0;
    end
  end

  // Bus handshake: data_req_o is valid and data_addr_ok_i is ready; the request
  // transfers on a rising edge where both are high, and once raised data_req_o
  // with its fields stays stable until that edge, even across a flush.
  assign data_req_o   = (state_q == S_REQ) || ((state_q == S_DRAIN) && pend_q);
  assign data_wr_o    = req_we;
  assign data_size_o  = req_size;
  assign data_wstrb_o = req_sel;
  assign data_addr_o  = req_addr;
  assign data_wdata_o = req_wdata;

  assign mem_rdata_o  = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign stall_req_o  = !flush_i && (((state_q == S_IDLE) && mem_ce_i) ||
                                     (state_q == S_REQ) || (state_q == S_WAIT) ||
                                     ((state_q == S_DRAIN) && mem_ce_i));
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_dbus_bridge.sv
// Directed bench for mem_dbus_bridge: hand-timed bus acks per cycle, with an
// expected-address queue checking every accepted bus request.
module tb_mem_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, pipe_stall_i, flush_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [31:0] mem_rdata_o;
  logic        stall_req_o, data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_WAIT = 3'd2,
                         ST_DONE = 3'd3, ST_DRAIN = 3'd4;

  int checks = 0;
  int failures = 0;
  int stall_cnt;
  logic [31:0] exp_q[$];

  mem_dbus_bridge dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .pipe_stall_i(pipe_stall_i), .flush_i(flush_i),
    .mem_rdata_o(mem_rdata_o), .stall_req_o(stall_req_o),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_wstrb_o(data_wstrb_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
    .data_rdata_i(data_rdata_i), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted request must match the next expected address
  always @(negedge clk) begin
    #2;
    if (rst && data_req_o && data_addr_ok_i) begin
      if (exp_q.size() == 0) check("bus_req_unexpected", data_addr_o, 32'hFFFF_FFFF);
      else check("bus_req_addr", data_addr_o, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic bus_idle();
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'd0;
  endtask

  task automatic mem_access(input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] data);
    mem_ce_i   = 1'b1;
    mem_we_i   = we;
    mem_sel_i  = sel;
    mem_addr_i = addr;
    mem_data_i = data;
  endtask

  task automatic mem_none();
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_sel_i  = 4'd0;
    mem_addr_i = 32'd0;
    mem_data_i = 32'd0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    pipe_stall_i = 1'b0;
    flush_i = 1'b0;
    mem_none();
    bus_idle();
    next_cycle();
    next_cycle();
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_req", data_req_o, 0);
    check("rst_addr", data_addr_o, 0);
    check("rst_rdata", mem_rdata_o, 0);
    check("rst_stall", stall_req_o, 0);
    next_cycle();
    rst = 1'b1;

    // aligned LW at 0x1000, addr_ok and data_ok each one cycle late
    next_cycle();
    mem_access(1'b0, 4'b1111, 32'h0000_1000, 32'd0);
    exp_q.push_back(32'h0000_1000);
    #1;
    check("lw_idle_stall", stall_req_o, 1);
    check("lw_idle_noreq", data_req_o, 0);
    stall_cnt = 0;
    next_cycle();
    #1;
    check("lw_req_state", dbg_state, ST_REQ);
    check("lw_req_valid", data_req_o, 1);
    check("lw_size", data_size_o, 2);
    check("lw_wr", data_wr_o, 0);
    if (stall_req_o) stall_cnt++;
    next_cycle();
    data_addr_ok_i = 1'b1;
    #1;
    check("lw_req_held", data_req_o, 1);
    if (stall_req_o) stall_cnt++;
    next_cycle();
    bus_idle();
    #1;
    check("lw_wait_state", dbg_state, ST_WAIT);
    check("lw_wait_noreq", data_req_o, 0);
    if (stall_req_o) stall_cnt++;
    next_cycle();
    data_data_ok_i = 1'b1;
    data_rdata_i = 32'hDEAD_BEEF;
    #1;
    if (stall_req_o) stall_cnt++;
    next_cycle();
    bus_idle();
    #1;
    check("lw_stall_cycles", stall_cnt, 4);
    check("lw_done_state", dbg_state, ST_DONE);
    check("lw_done_stall", stall_req_o, 0);
    check("lw_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    next_cycle();
    mem_none();
    #1;
    check("lw_back_idle", dbg_state, ST_IDLE);
    check("lw_idle_rdata", mem_rdata_o, 0);

    // SB to 0x1003, then DONE held by pipe_stall for 3 cycles
    next_cycle();
    mem_access(1'b1, 4'b1000, 32'h0000_1003, 32'hAB00_0000);
    exp_q.push_back(32'h0000_1003);
    next_cycle();
    data_addr_ok_i = 1'b1;
    #1;
    check("sb_size", data_size_o, 0);
    check("sb_addr", data_addr_o, 32'h0000_1003);
    check("sb_wr", data_wr_o, 1);
    check("sb_wstrb", data_wstrb_o, 4'b1000);
    check("sb_wdata", data_wdata_o, 32'hAB00_0000);
    next_cycle();
    bus_idle();
    data_data_ok_i = 1'b1;
    data_rdata_i = 32'h1234_5678;
    #1;
    check("sb_wait_stall", stall_req_o, 1);
    next_cycle();
    bus_idle();
    pipe_stall_i = 1'b1;
    #1;
    check("sb_stall_drop", stall_req_o, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_state", dbg_state, ST_DONE);
      check("hold_noreq", data_req_o, 0);
      check("hold_rdata", mem_rdata_o, 32'h1234_5678);
      next_cycle();
    end
    pipe_stall_i = 1'b0;
    #1;
    check("hold_last_done", dbg_state, ST_DONE);
    next_cycle();
    mem_none();
    #1;
    check("hold_release_idle", dbg_state, ST_IDLE);

    // flush in REQ before addr_ok; new LW queued behind the drain
    next_cycle();
    mem_access(1'b0, 4'b1111, 32'h0000_3000, 32'd0);
    exp_q.push_back(32'h0000_3000);
    next_cycle();
    flush_i = 1'b1;
    #1;
    check("fl_stall_zero", stall_req_o, 0);
    check("fl_req_kept", data_req_o, 1);
    next_cycle();
    flush_i = 1'b0;
    mem_access(1'b0, 4'b1111, 32'h0000_4000, 32'd0);
    #1;
    check("fl_drain_state", dbg_state, ST_DRAIN);
    check("fl_drain_req", data_req_o, 1);
    check("fl_drain_addr", data_addr_o, 32'h0000_3000);
    check("fl_drain_stall", stall_req_o, 1);
    next_cycle();
    data_addr_ok_i = 1'b1;
    next_cycle();
    bus_idle();
    #1;
    check("fl_drain_noreq", data_req_o, 0);
    check("fl_drain_wait", dbg_state, ST_DRAIN);
    next_cycle();
    data_data_ok_i = 1'b1;
    data_rdata_i = 32'hBAD0_BAD0;
    #1;
    check("fl_drain_stall2", stall_req_o, 1);
    next_cycle();
    bus_idle();
    exp_q.push_back(32'h0000_4000);
    #1;
    check("fl_exit_idle", dbg_state, ST_IDLE);
    check("fl_exit_noreq", data_req_o, 0);
    check("fl_exit_rdata", mem_rdata_o, 0);
    next_cycle();
    data_addr_ok_i = 1'b1;
    #1;
    check("fl_new_req", data_req_o, 1);
    check("fl_new_addr", data_addr_o, 32'h0000_4000);
    next_cycle();
    bus_idle();
    data_data_ok_i = 1'b1;
    data_rdata_i = 32'h0000_4444;
    next_cycle();
    bus_idle();
    #1;
    check("fl_new_rdata", mem_rdata_o, 32'h0000_4444);
    next_cycle();
    mem_none();

    // LH upper half: sel 1100 -> size 1, addr offset 2
    next_cycle();
    mem_access(1'b0, 4'b1100, 32'h0000_5000, 32'd0);
    exp_q.push_back(32'h0000_5002);
    next_cycle();
    data_addr_ok_i = 1'b1;
    #1;
    check("lh_size", data_size_o, 1);
    check("lh_addr", data_addr_o, 32'h0000_5002);
    next_cycle();
    bus_idle();
    data_data_ok_i = 1'b1;
    data_rdata_i = 32'h7777_0000;
    next_cycle();
    bus_idle();
    mem_none();
    #1;
    check("lh_rdata", mem_rdata_o, 32'h7777_0000);
    next_cycle();

    // illegal sel completes without a bus access
    mem_access(1'b0, 4'b0101, 32'h0000_6000, 32'd0);
    #1;
    check("bad_idle_stall", stall_req_o, 1);
    next_cycle();
    #1;
    check("bad_done_state", dbg_state, ST_DONE);
    check("bad_noreq", data_req_o, 0);
    check("bad_stall", stall_req_o, 0);
    check("bad_rdata", mem_rdata_o, 0);
    next_cycle();
    mem_none();

    // SWL at 0x2000, then async reset while waiting for data_ok
    next_cycle();
    mem_access(1'b1, 4'b0111, 32'h0000_2000, 32'h0011_2233);
    exp_q.push_back(32'h0000_2000);
    next_cycle();
    data_addr_ok_i = 1'b1;
    #1;
    check("swl_size", data_size_o, 2);
    check("swl_addr", data_addr_o, 32'h0000_2000);
    check("swl_wstrb", data_wstrb_o, 4'b0111);
    next_cycle();
    bus_idle();
    mem_none();
    #1;
    check("swl_wait_state", dbg_state, ST_WAIT);
    #1;
    rst = 1'b0;
    #1;
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_req", data_req_o, 0);
    check("arst_wr", data_wr_o, 0);
    check("arst_addr", data_addr_o, 0);
    check("arst_wstrb", data_wstrb_o, 0);
    check("arst_wdata", data_wdata_o, 0);
    check("arst_stall", stall_req_o, 0);
    check("arst_rdata", mem_rdata_o, 0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
